ram: RTL and testbench
======================

RAM -- requirements
Module: ram

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, address width; depth SHALL be 2**ADDR_WIDTH words (16 by default).
REQ-002 Parameter DATA_WIDTH, default 4, word width in bits.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 data_out  output  DATA_WIDTH  registered read data.
REQ-006 data_in  input  DATA_WIDTH  write data.
REQ-007 addr  input  ADDR_WIDTH  word address, shared by reads and writes.
REQ-008 write  input  1  1 = write, 0 = read; qualified by select.
REQ-009 select  input  1  chip select, active high; the block SHALL ignore write and addr while select is low.

Function
REQ-010 Storage SHALL be a single-port array of 2**ADDR_WIDTH words of DATA_WIDTH bits.
REQ-011 Write: on a rising clk with select=1 and write=1, mem[addr] SHALL take data_in.
- data_out SHALL remain unchanged in a write cycle.
REQ-012 Read: on a rising clk with select=1 and write=0, data_out SHALL take mem[addr].
- Latency is exactly 1 cycle: the value is visible after the edge that samples addr.
REQ-013 Idle: with select=0, memory and data_out SHALL hold their values, whatever write and addr are.
REQ-014 Width: data_in SHALL be stored bit-exact with no extension or truncation; addr covers the full depth, so out-of-range addresses cannot occur.
REQ-015 Write then read: a read of an address in the cycle after a write to it SHALL return the new data.
- Only one operation per cycle is possible, so no read-during-write bypass is required.
REQ-016 data_out SHALL never be X or Z after reset has been applied.
- A read of a never-written word SHALL return 0.

Reset
REQ-017 Asserting rst SHALL immediately clear data_out and every memory word to 0, independent of clk.
REQ-018 While rst is high, writes and reads SHALL be blocked.
REQ-019 The first operation SHALL be accepted on the first rising clk after rst deasserts.
REQ-020 Reset asserted mid-sequence SHALL discard all prior contents; a subsequent read of any address SHALL return 0.

Structure
REQ-021 A shared package ram_pkg SHALL hold the default ADDR_WIDTH and DATA_WIDTH constants and the addr and data word typedefs.
REQ-022 The block SHALL be a single module with no sub-modules.
- Memory SHALL be a flop array, because a per-word asynchronous clear prevents block-RAM inference.

Verification
REQ-023 Reset clear: assert rst, release it, then read addresses 0..15 -> data_out = 0 for every address, one cycle after each request.
REQ-024 Basic write/read:
- Stimulus: write 6 to addr 3, then read addr 3.
- Required response: data_out = 6 on the edge after the read request; data_out unchanged during the write cycle.
REQ-025 Pattern fill:
- Stimulus: write (2*k) mod 16 to addr k for k = 0..8, then read addr 0..8 in order.
- Required response: data_out = 0,2,4,6,8,10,12,14,0.
REQ-026 Deselect hold:
- Stimulus: after reading 10 from addr 5, drive select=0 with write=1, addr=5, data_in=15 for 3 cycles, then read addr 5.
- Required response: data_out stays 10 throughout, and the final read returns 10.
REQ-027 Random reads: 20 reads at random addresses 0..7 after the pattern fill -> each data_out = (2*addr) mod 16.
REQ-028 Mid-operation reset:
- Stimulus: write 9 to addr 7, pulse rst between clock edges, then read addr 7.
- Required response: data_out = 0 as soon as rst asserts, and the read returns 0.

Source files
------------

// File: rtl/ram_pkg.sv
// ram_pkg: default geometry and word typedefs shared by the RAM and its users.
package ram_pkg;
    localparam int RAM_ADDR_WIDTH = 4;
    localparam int RAM_DATA_WIDTH = 4;
    typedef logic [RAM_ADDR_WIDTH-1:0] addr_t;
    typedef logic [RAM_DATA_WIDTH-1:0] data_t;
endpackage

// File: rtl/ram.sv
// ram: single-port flop-array RAM with registered read data and async clear.
module ram
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = RAM_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  write,
    input  logic                  select,
    output logic [DATA_WIDTH-1:0] data_out
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    // Flops rather than block RAM: every word must clear asynchronously.
    always_comb data_out_d = (select && !write) ? mem_q[addr] : data_out_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            data_out_q <= '0;
        end else begin
            if (select && write) mem_q[addr] <= data_in;
            data_out_q <= data_out_d;
        end
    end
    assign data_out = data_out_q;
endmodule

// File: tb/tb_ram.sv
// tb_ram: randomized and directed checks of ram against an array-based reference model.
module tb_ram;
    logic       clk = 0, rst = 1;
    logic [3:0] data_in = 0, addr = 0;
    logic       write = 0, select = 0;
    logic [3:0] data_out;
    int         checks = 0, errors = 0;
    int         model [16];
    int         exp_out = 0;

    ram dut (.clk(clk), .rst(rst), .data_in(data_in), .addr(addr), .write(write),
             .select(select), .data_out(data_out));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input int want);
        checks++;
        if (got !== 4'(want)) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) model[i] = 0;
        exp_out = 0;
    endtask

    task automatic op(input string tag, input bit sel, input bit wr, input int a, input int d);
        @(negedge clk);
        select = sel; write = wr; addr = 4'(a); data_in = 4'(d);
        @(posedge clk);
        if (sel && wr) model[a] = d % 16;
        else if (sel) exp_out = model[a];
        #1 check(tag, data_out, exp_out);
    endtask

    initial begin
        clear_model();
        #2 check("reset_out", data_out, 0);
        @(negedge clk) rst = 0;
        for (int a = 0; a < 16; a++) op("reset_read", 1, 0, a, 0);
        op("wr_hold", 1, 1, 3, 6);
        check("wr_unchanged", data_out, 0);
        op("rd3", 1, 0, 3, 0);
        check("rd3_is6", data_out, 6);
        for (int k = 0; k <= 8; k++) op("fill_wr", 1, 1, k, (2 * k) % 16);
        for (int k = 0; k <= 8; k++) begin
            op("fill_rd", 1, 0, k, 0);
            check("fill_val", data_out, (2 * k) % 16);
        end
        op("wr5", 1, 1, 5, 10);
        op("rd5", 1, 0, 5, 0);
        for (int i = 0; i < 3; i++) begin
            op("desel", 0, 1, 5, 15);
            check("desel_hold", data_out, 10);
        end
        op("rd5_again", 1, 0, 5, 0);
        check("rd5_is10", data_out, 10);
        for (int i = 0; i < 20; i++) begin
            int a = $urandom_range(0, 7);
            op("rand_rd", 1, 0, a, 0);
            check("rand_formula", data_out, (2 * a) % 16);
        end
        for (int i = 0; i < 60; i++)
            op("rand_mix", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
               $urandom_range(0, 15), $urandom_range(0, 15));
        op("wr7", 1, 1, 7, 9);
        op("rd7", 1, 0, 7, 0);
        check("rd7_is9", data_out, 9);
        op("wr7b", 1, 1, 7, 9);
        #2 rst = 1;
        clear_model();
        #1 check("async_clear", data_out, 0);
        @(negedge clk);
        select = 1; write = 1; addr = 7; data_in = 4'hf;
        @(posedge clk);
        #1 check("rst_block", data_out, 0);
        @(negedge clk) rst = 0;
        select = 0;
        op("post_rst_rd7", 1, 0, 7, 0);
        for (int i = 0; i < 8; i++) op("post_rst_rd", 1, 0, $urandom_range(0, 15), 0);
        op("first_wr", 1, 1, 2, 13);
        op("first_rd", 1, 0, 2, 0);
        check("first_rd_13", data_out, 13);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
